// File: rtl/spm_sequencer.sv
// Control sequencer for a signed serial-parallel multiplier. It streams the
// sign-extended multiplier LSB-first and collects the serial product bits.
module spm_sequencer #(
    parameter int W     = 8,
    parameter int P_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     mcand,
    input  logic [W-1:0]     mplier,
    output logic             busy,
    output logic             done,
    output logic             spm_clr,
    output logic [W-1:0]     spm_y,
    output logic             spm_x,
    input  logic             spm_p,
    output logic [2*W-1:0]   product,
    output logic             prod_neg,
    output logic [2*W-2:0]   prod_mag
);

    localparam int LAST = 2 * W + P_LAT - 1;
    localparam int CW   = $clog2(LAST + 1);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     y_q, y_d;
    logic [W-1:0]     x_sh_q, x_sh_d;
    // Only the upper 2W-1 bits of the product shifter are kept: the final
    // incoming bit is merged on the fly when the result is registered.
    logic [2*W-2:0]   p_sh_q, p_sh_d;
    logic [2*W-1:0]   product_q, product_d;
    logic             neg_q, neg_d;
    logic [2*W-2:0]   mag_q, mag_d;

    logic [2*W-1:0]   p_cap;
    logic             cap_en;

    assign p_cap = {spm_p, p_sh_q};

    // With zero core latency every RUN cycle carries a valid product bit.
    generate
        if (P_LAT == 0) begin : g_cap_always
            assign cap_en = 1'b1;
        end else begin : g_cap_delayed
            assign cap_en = (cnt_q >= CW'(P_LAT));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        x_sh_d    = x_sh_q;
        p_sh_d    = p_sh_q;
        product_d = product_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    y_d     = mcand;
                    x_sh_d  = mplier;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
                cnt_d   = '0;
                p_sh_d  = '0;
            end
            S_RUN: begin
                x_sh_d = {x_sh_q[W-1], x_sh_q[W-1:1]};
                cnt_d  = cnt_q + ONE_C;
                if (cap_en) begin
                    p_sh_d = p_cap[2*W-1:1];
                end
                if (cnt_q == LAST_C) begin
                    state_d   = S_DONE;
                    product_d = p_cap;
                    neg_d     = p_cap[2*W-1];
                    mag_d     = p_cap[2*W-1] ? (~p_cap[2*W-2:0] + 1'b1)
                                             : p_cap[2*W-2:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            x_sh_q    <= '0;
            p_sh_q    <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
            mag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            x_sh_q    <= x_sh_d;
            p_sh_q    <= p_sh_d;
            product_q <= product_d;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign spm_clr  = (state_q == S_CLEAR);
    assign spm_x    = (state_q == S_RUN) & x_sh_q[0];
    assign spm_y    = y_q;
    assign product  = product_q;
    assign prod_neg = neg_q;
    assign prod_mag = mag_q;

endmodule

// File: tb/tb_spm_sequencer.sv
// Bench for spm_sequencer: three instances (P_LAT 1, 0, 3), each driving a
// behavioural SPM core, checked against plain signed multiplication.
module tb_spm_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start_m = 1'b0;
    logic         start_s = 1'b0;
    logic [W-1:0] mcand   = '0;
    logic [W-1:0] mplier  = '0;

    logic           busy_a [3];
    logic           done_a [3];
    logic           clr_a  [3];
    logic           x_a    [3];
    logic           p_a    [3];
    logic [W-1:0]   y_a    [3];
    logic [2*W-1:0] prod_a [3];
    logic           neg_a  [3];
    logic [2*W-2:0] mag_a  [3];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int PL = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

            spm_sequencer #(.W(W), .P_LAT(PL)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    ((gi == 0) ? start_m : start_s),
                .mcand    (mcand),
                .mplier   (mplier),
                .busy     (busy_a[gi]),
                .done     (done_a[gi]),
                .spm_clr  (clr_a[gi]),
                .spm_y    (y_a[gi]),
                .spm_x    (x_a[gi]),
                .spm_p    (p_a[gi]),
                .product  (prod_a[gi]),
                .prod_neg (neg_a[gi]),
                .prod_mag (mag_a[gi])
            );

            // SPM core model: bit k of sext(x)*sext(y), where x is the bit
            // stream received since the last clear, delayed by PL clocks.
            logic [2*W-1:0] xacc = '0;
            logic [4:0]     k    = 5'd16;
            logic [3:0]     dly  = '0;
            logic [2*W-1:0] cur, pr;
            logic           pbit;

            always_comb begin
                cur = xacc;
                if (k < 5'd16) cur[k[3:0]] = x_a[gi];
                pr   = cur * {{W{y_a[gi][W-1]}}, y_a[gi]};
                pbit = (k < 5'd16) ? pr[k[3:0]] : 1'b0;
            end

            always @(posedge clk) begin
                if (clr_a[gi]) begin
                    xacc <= '0;
                    k    <= 5'd0;
                end else if (k < 5'd16) begin
                    xacc[k[3:0]] <= x_a[gi];
                    k            <= k + 5'd1;
                end
                dly <= {dly[2:0], pbit};
            end

            if (PL == 0) begin : g_nodly
                assign p_a[gi] = pbit;
            end else begin : g_dly
                assign p_a[gi] = dly[PL-1];
            end
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input int i, input int e, input string tag);
        int mag;
        mag = (e < 0) ? -e : e;
        chk({tag, "_product"}, {16'h0, prod_a[i]}, e & 32'hFFFF);
        chk({tag, "_neg"}, {31'h0, neg_a[i]}, (e < 0) ? 32'd1 : 32'd0);
        chk({tag, "_mag"}, {17'h0, mag_a[i]}, mag & 32'h7FFF);
    endtask

    // Main instance (P_LAT=1): one op, start sampled at edge 0. done is high
    // in the clock ending at edge 2W+P_LAT+2, i.e. first seen after edge 2W+P_LAT+1.
    task automatic op_main(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                           input string tag);
        int n;
        int e;
        @(negedge clk);
        mcand   = a;
        mplier  = b;
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        chk({tag, "_clr"}, {31'h0, clr_a[0]}, 32'd1);
        chk({tag, "_busy"}, {31'h0, busy_a[0]}, 32'd1);
        n = 0;
        while (done_a[0] !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 2 * W + 1 + 1);
        e = int'(a) * int'(b);
        chk_result(0, e, tag);
        $display("op %s: %0d * %0d -> product %0d (expected %0d) after %0d edges",
                 tag, a, b, $signed(prod_a[0]), e, n);
        @(posedge clk);
        #1;
        chk({tag, "_done_end"}, {31'h0, done_a[0]}, 32'd0);
        chk({tag, "_idle"}, {31'h0, busy_a[0]}, 32'd0);
    endtask

    // P_LAT=0 and P_LAT=3 instances run the same operands together.
    task automatic op_sweep(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int n;
        int e;
        logic g1, g2;
        @(negedge clk);
        mcand   = a;
        mplier  = b;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        e  = int'(a) * int'(b);
        n  = 0;
        g1 = 1'b0;
        g2 = 1'b0;
        while (!(g1 && g2) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done_a[1] && !g1) begin
                g1 = 1'b1;
                chk("sweep_p0_latency", n, 2 * W + 0 + 1);
                chk_result(1, e, "sweep_p0");
            end
            if (done_a[2] && !g2) begin
                g2 = 1'b1;
                chk("sweep_p3_latency", n, 2 * W + 3 + 1);
                chk_result(2, e, "sweep_p3");
            end
        end
        chk("sweep_both_done", {30'h0, g1, g2}, 32'd3);
        $display("sweep: %0d * %0d -> P0 %0d, P3 %0d (expected %0d)",
                 a, b, $signed(prod_a[1]), $signed(prod_a[2]), e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dn;
        logic [2*W-1:0] pr;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy_a[0]}, 32'd0);
        chk("rst_done", {31'h0, done_a[0]}, 32'd0);
        chk("rst_clr", {31'h0, clr_a[0]}, 32'd0);
        chk("rst_x", {31'h0, x_a[0]}, 32'd0);
        chk("rst_y", {24'h0, y_a[0]}, 32'd0);
        chk("rst_product", {16'h0, prod_a[0]}, 32'd0);
        chk("rst_neg", {31'h0, neg_a[0]}, 32'd0);
        chk("rst_mag", {17'h0, mag_a[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed products, including the extreme magnitudes
        op_main(8'sd5, 8'sd3, "t1_5x3");
        op_main(-8'sd7, 8'sd6, "t2_m7x6");
        op_main(-8'sd128, -8'sd128, "t3_m128xm128");
        op_main(8'sd127, -8'sd128, "t3_127xm128");

        // Starts while busy (mid-RUN and in the DONE cycle) are dropped,
        // and operand changes after acceptance have no effect.
        @(negedge clk);
        mcand   = 8'd4;
        mplier  = 8'd4;
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        dn = 0;
        pr = '0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            #1;
            mcand  = W'($urandom);
            mplier = W'($urandom);
            if (done_a[0]) begin
                dn++;
                pr = prod_a[0];
            end
            start_m = (n == 5) || done_a[0];
        end
        start_m = 1'b0;
        chk("t4_done_count", dn, 1);
        chk("t4_product", {16'h0, pr}, 32'd16);
        chk("t4_idle", {31'h0, busy_a[0]}, 32'd0);
        $display("op t4_4x4_restarts: dones %0d product %0d", dn, pr);
        op_main(-8'sd3, 8'sd11, "t4_next");

        // Asynchronous reset at RUN cnt=6 of 9*9
        @(negedge clk);
        mcand   = 8'd9;
        mplier  = 8'd9;
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_busy", {31'h0, busy_a[0]}, 32'd0);
        chk("t5_done", {31'h0, done_a[0]}, 32'd0);
        chk("t5_clr", {31'h0, clr_a[0]}, 32'd0);
        chk("t5_x", {31'h0, x_a[0]}, 32'd0);
        chk("t5_y", {24'h0, y_a[0]}, 32'd0);
        chk("t5_product", {16'h0, prod_a[0]}, 32'd0);
        chk("t5_neg", {31'h0, neg_a[0]}, 32'd0);
        chk("t5_mag", {17'h0, mag_a[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done_a[0]) dn++;
        end
        chk("t5_no_done", dn, 0);
        $display("op t5_reset_9x9: dones after reset %0d", dn);
        op_main(8'sd2, 8'sd3, "t5_2x3");

        // Random back-to-back ops on the main instance
        for (int r = 0; r < 6; r++) begin
            op_main(W'($urandom), W'($urandom), "rand_main");
        end

        // Full sweep of one operand on the P_LAT=0 and P_LAT=3 instances
        for (int i = -128; i < 128; i++) begin
            op_sweep(W'(i), W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
